// File: rtl/rx_reset_sm.sv
// Per-channel RX reset sequencer: pulses SERDES reset, then holds PCS reset until CDR lock
// and signal presence qualify; re-sequences on loss and keeps a saturating retry count.
module rx_reset_sm #(
  parameter int T1_BIT = 2,
  parameter int T2_BIT = 18
) (
  input  logic       refclkdiv2,
  input  logic       rst_n,
  input  logic       tx_pcs_rst_c,
  input  logic       rx_cdr_lol_ch,
  input  logic       rx_los_low_ch,
  output logic       rx_serdes_rst_ch_c,
  output logic       rx_pcs_rst_ch_c,
  output logic       rx_ready,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    WAIT_TX   = 3'd0,
    APPLY_RST = 3'd1,
    WAIT_T1   = 3'd2,
    RELEASE   = 3'd3,
    WAIT_T2   = 3'd4,
    NORMAL    = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      lol_sync;
  logic [1:0]      los_sync;
  logic            lol_s;
  logic            los_s;
  logic            bad;
  logic [T1_BIT:0] counter1;
  logic [T2_BIT:0] counter2;
  logic            t1_done;
  logic            t2_done;
  logic            retry_evt;

  // Chains preset to "bad" so a fresh reset never looks locked before real samples arrive.
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      lol_sync <= 2'b11;
      los_sync <= 2'b11;
    end else begin
      lol_sync <= {lol_sync[0], rx_cdr_lol_ch};
      los_sync <= {los_sync[0], rx_los_low_ch};
    end
  end

  assign lol_s   = lol_sync[1];
  assign los_s   = los_sync[1];
  assign bad     = lol_s | los_s;
  assign t1_done = counter1[T1_BIT];
  assign t2_done = counter2[T2_BIT];

  always_comb begin
    state_nxt = state;
    retry_evt = 1'b0;
    if (tx_pcs_rst_c && (state != WAIT_TX)) begin
      state_nxt = WAIT_TX;
    end else begin
      case (state)
        WAIT_TX:   if (!tx_pcs_rst_c) state_nxt = APPLY_RST;
        APPLY_RST: state_nxt = WAIT_T1;
        WAIT_T1:   if (t1_done) state_nxt = RELEASE;
        RELEASE:   state_nxt = WAIT_T2;
        WAIT_T2: begin
          // Lock status is only judged once the qualification window has elapsed.
          if (t2_done) begin
            if (bad) begin
              state_nxt = APPLY_RST;
              retry_evt = 1'b1;
            end else begin
              state_nxt = NORMAL;
            end
          end
        end
        NORMAL: begin
          if (bad) begin
            state_nxt = APPLY_RST;
            retry_evt = 1'b1;
          end
        end
        default:   state_nxt = WAIT_TX;
      endcase
    end
  end

  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      state              <= WAIT_TX;
      rx_serdes_rst_ch_c <= 1'b1;
      rx_pcs_rst_ch_c    <= 1'b1;
      rx_ready           <= 1'b0;
      retry_cnt          <= 4'd0;
      counter1           <= '0;
      counter2           <= '0;
    end else begin
      state              <= state_nxt;
      // Outputs decode the next state so they move on the same edge as the state register.
      rx_serdes_rst_ch_c <= !((state_nxt == RELEASE) || (state_nxt == WAIT_T2) ||
                              (state_nxt == NORMAL));
      rx_pcs_rst_ch_c    <= (state_nxt != NORMAL);
      rx_ready           <= (state_nxt == NORMAL);
      if (retry_evt && (retry_cnt != 4'd15)) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
      if (state == APPLY_RST) begin
        counter1 <= '0;
      end else if ((state == WAIT_T1) && !t1_done) begin
        counter1 <= counter1 + (T1_BIT + 1)'(1);
      end
      if (state == RELEASE) begin
        counter2 <= '0;
      end else if ((state == WAIT_T2) && !t2_done) begin
        counter2 <= counter2 + (T2_BIT + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_reset_sm.sv
// Directed bench for rx_reset_sm with T1_BIT=2, T2_BIT=4.
module tb_rx_reset_sm;

  logic       refclkdiv2 = 1'b0;
  logic       rst_n;
  logic       tx_pcs_rst_c;
  logic       lol;
  logic       los;
  logic       serdes_rst;
  logic       pcs_rst;
  logic       ready;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 refclkdiv2 = ~refclkdiv2;

  rx_reset_sm #(.T1_BIT(2), .T2_BIT(4)) dut (
    .refclkdiv2         (refclkdiv2),
    .rst_n              (rst_n),
    .tx_pcs_rst_c       (tx_pcs_rst_c),
    .rx_cdr_lol_ch      (lol),
    .rx_los_low_ch      (los),
    .rx_serdes_rst_ch_c (serdes_rst),
    .rx_pcs_rst_ch_c    (pcs_rst),
    .rx_ready           (ready),
    .retry_cnt          (retry_cnt)
  );

  // Counts consecutive negedge samples (starting with the current one) where the selected
  // reset output is high; sel 0 = serdes reset, 1 = pcs reset.
  task automatic count_run(input int sel, output int n);
    n = 0;
    while ((((sel == 0) ? serdes_rst : pcs_rst) === 1'b1) && (n < 100)) begin
      n++;
      @(negedge refclkdiv2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; tx_pcs_rst_c = 1'b1; lol = 1'b0; los = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_async: outs=%b retry=%0d expected outs=110 retry=0",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    repeat (2) @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_hold: outs=%b retry=%0d expected outs=110 retry=0",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
  endtask

  task automatic test_bringup();
    int n;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge refclkdiv2);
      checks++;
      if ({serdes_rst, pcs_rst, ready} !== 3'b110) begin
        errors++; $display("FAIL tx_hold cycle %0d: outs=%b expected 110", i,
                           {serdes_rst, pcs_rst, ready});
      end
    end
    tx_pcs_rst_c = 1'b0;
    @(negedge refclkdiv2);
    count_run(0, n);
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL bringup_serdes_len: got %0d cycles expected 6", n);
    end
    count_run(1, n);
    checks++;
    if (n != 18) begin
      errors++; $display("FAIL bringup_pcs_len: got %0d cycles expected 18", n);
    end
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b001 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL bringup_normal: outs=%b retry=%0d expected outs=001 retry=0",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
  endtask

  task automatic test_lock_retry();
    int n; int rises; logic prev; logic done;
    tx_pcs_rst_c = 1'b1; lol = 1'b1;
    @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL retry_restart: outs=%b retry=%0d expected outs=110 retry=0",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    tx_pcs_rst_c = 1'b0;
    prev = serdes_rst; rises = 0; n = 0; done = 1'b0;
    for (int i = 1; i <= 200 && !done; i++) begin
      @(negedge refclkdiv2);
      n = i;
      if (serdes_rst && !prev) begin
        rises++;
        lol = 1'b0;
      end
      prev = serdes_rst;
      if (ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL retry_timeout: ready=%b after 200 cycles expected 1", ready);
    end
    checks++;
    if (n != 49) begin
      errors++; $display("FAIL retry_latency: ready after %0d edges expected 49", n);
    end
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL retry_extra_apply: got %0d expected 1", rises);
    end
    checks++;
    if (retry_cnt !== 4'd1) begin
      errors++; $display("FAIL retry_cnt_one: got %0d expected 1", retry_cnt);
    end
  endtask

  task automatic test_loss_in_normal();
    int n;
    los = 1'b1;
    @(negedge refclkdiv2);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL loss_edge_k: ready=%b expected 1", ready);
    end
    @(negedge refclkdiv2);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL loss_edge_k1: ready=%b expected 1", ready);
    end
    @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110) begin
      errors++; $display("FAIL loss_edge_k2: outs=%b expected 110", {serdes_rst, pcs_rst, ready});
    end
    los = 1'b0;
    count_run(0, n);
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL loss_serdes_len: got %0d expected 6", n);
    end
    count_run(1, n);
    checks++;
    if (n != 18) begin
      errors++; $display("FAIL loss_pcs_len: got %0d expected 18", n);
    end
    checks++;
    if (ready !== 1'b1 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL loss_recover: ready=%b retry=%0d expected ready=1 retry=2",
                         ready, retry_cnt);
    end
  endtask

  task automatic test_tx_override();
    int n; logic done;
    tx_pcs_rst_c = 1'b1;
    @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL txov_normal: outs=%b retry=%0d expected outs=110 retry=2",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    tx_pcs_rst_c = 1'b0;
    repeat (3) @(negedge refclkdiv2);
    tx_pcs_rst_c = 1'b1;
    @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110) begin
      errors++; $display("FAIL txov_t1: outs=%b expected 110", {serdes_rst, pcs_rst, ready});
    end
    tx_pcs_rst_c = 1'b0;
    @(negedge refclkdiv2);
    count_run(0, n);
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL txov_t1_restart_len: got %0d expected 6", n);
    end
    lol = 1'b1;
    repeat (17) @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b010) begin
      errors++; $display("FAIL txov_t2_last: outs=%b expected 010", {serdes_rst, pcs_rst, ready});
    end
    tx_pcs_rst_c = 1'b1;
    @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL txov_t2_done: outs=%b retry=%0d expected outs=110 retry=2",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    lol = 1'b0; tx_pcs_rst_c = 1'b0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge refclkdiv2);
      if (ready) done = 1'b1;
    end
    checks++;
    if (!done || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL txov_recover: ready=%b retry=%0d expected ready=1 retry=2",
                         ready, retry_cnt);
    end
  endtask

  task automatic test_retry_saturate();
    int rises; int expv; logic prev; logic ever_ready;
    lol = 1'b1;
    prev = serdes_rst; rises = 0; ever_ready = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge refclkdiv2);
      if (i >= 3 && ready) ever_ready = 1'b1;
      if (serdes_rst && !prev) begin
        rises++;
        expv = (2 + rises > 15) ? 15 : 2 + rises;
        checks++;
        if (retry_cnt !== expv[3:0]) begin
          errors++; $display("FAIL sat_step %0d: retry=%0d expected %0d", rises, retry_cnt, expv);
        end
      end
      prev = serdes_rst;
    end
    checks++;
    if (rises != 25) begin
      errors++; $display("FAIL sat_pulses: got %0d expected 25", rises);
    end
    checks++;
    if (retry_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_final: retry=%0d expected 15", retry_cnt);
    end
    checks++;
    if (ever_ready !== 1'b0) begin
      errors++; $display("FAIL sat_ready: ready seen=%b expected 0", ever_ready);
    end
  endtask

  task automatic test_rst_mid_t2();
    int n; logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge refclkdiv2);
      if (serdes_rst) found = 1'b1;
    end
    for (int i = 0; i < 40 && found; i++) begin
      @(negedge refclkdiv2);
      if (!serdes_rst) break;
    end
    repeat (5) @(negedge refclkdiv2);
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b010 || retry_cnt !== 4'd15) begin
      errors++; $display("FAIL rst_mid_pre: outs=%b retry=%0d expected outs=010 retry=15",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({serdes_rst, pcs_rst, ready} !== 3'b110 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid_async: outs=%b retry=%0d expected outs=110 retry=0",
                         {serdes_rst, pcs_rst, ready}, retry_cnt);
    end
    lol = 1'b0; tx_pcs_rst_c = 1'b0;
    repeat (2) @(negedge refclkdiv2);
    rst_n = 1'b1;
    @(negedge refclkdiv2);
    count_run(0, n);
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL rst_mid_serdes_len: got %0d expected 6", n);
    end
    count_run(1, n);
    checks++;
    if (n != 18) begin
      errors++; $display("FAIL rst_mid_pcs_len: got %0d expected 18", n);
    end
    checks++;
    if (ready !== 1'b1 || retry_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid_normal: ready=%b retry=%0d expected ready=1 retry=0",
                         ready, retry_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_retry();
    test_loss_in_normal();
    test_tx_override();
    test_retry_saturate();
    test_rst_mid_t2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
